// File: rtl/cnt_seq_pkg.sv
// ---------------------------------------------------------------------------
// cnt_seq_pkg
// Shared definitions for the counter_5bit fill/drain sequencer.
//   CNT_W            : width of the sequenced up/down counter
//   cnt_seq_state_t  : controller states (IDLE, CLR, UP, DOWN, DONE)
// ---------------------------------------------------------------------------
package cnt_seq_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } cnt_seq_state_t;

endpackage

// File: rtl/counter_5bit.sv
// ---------------------------------------------------------------------------
// counter_5bit
// Up/down counter with synchronous active-high reset and synchronous clear.
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   rst5       in   synchronous clear
//   cntU       in   increment
//   cntD       in   decrement
//   result     out  current count
//   down_done  out  high while the count is zero
// ---------------------------------------------------------------------------
module counter_5bit #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rst5,
  input  logic         cntU,
  input  logic         cntD,
  output logic [W-1:0] result,
  output logic         down_done
);

  logic [W-1:0] count;

  // Count register: reset and clear win over counting, increment over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (rst5) begin
      count <= {W{1'b0}};
    end else if (cntU) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else if (cntD) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign result    = count;
  assign down_done = (count == {W{1'b0}});

endmodule

// File: rtl/counter_5bit_seq_top.sv
// ---------------------------------------------------------------------------
// counter_5bit_seq_top
// Thin wrapper pairing the sequencer with its counter_5bit.
// Ports:
//   clk, rst (active-low async)       clock and reset
//   start, target, hold, abort        sequencer controls
//   cnt_val                           counter value (index for step consumers)
//   busy, step, done                  sequencer status
// ---------------------------------------------------------------------------
module counter_5bit_seq_top
  import cnt_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic             hold,
  input  logic             abort,
  output logic [CNT_W-1:0] cnt_val,
  output logic             busy,
  output logic             step,
  output logic             done
);

  logic cnt_rst;
  logic cnt_zero;
  logic rst5;
  logic cntU;
  logic cntD;

  // The counter's reset is synchronous and active-high.
  assign cnt_rst = ~rst;

  counter_5bit_seq #(.W(CNT_W)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .target   (target),
    .hold     (hold),
    .abort    (abort),
    .cnt_val  (cnt_val),
    .cnt_zero (cnt_zero),
    .rst5     (rst5),
    .cntU     (cntU),
    .cntD     (cntD),
    .busy     (busy),
    .step     (step),
    .done     (done)
  );

  counter_5bit #(.W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (cnt_rst),
    .rst5      (rst5),
    .cntU      (cntU),
    .cntD      (cntD),
    .result    (cnt_val),
    .down_done (cnt_zero)
  );

endmodule

// File: rtl/counter_5bit_seq.sv
// ---------------------------------------------------------------------------
// counter_5bit_seq
// Fill/drain sequencer for one counter_5bit instance. On start it clears the
// counter, counts up to the captured target, then counts back to zero with a
// step strobe per decrement, and finishes with a one-cycle done pulse.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous reset, active-low
//   start     in   begin a sequence (sampled in IDLE only)
//   target    in   fill count, captured on accepted start
//   hold      in   pause counting and state advance in UP/DOWN
//   abort     in   cancel a sequence in CLR/UP/DOWN
//   cnt_val   in   counter value
//   cnt_zero  in   counter is zero
//   rst5      out  counter clear
//   cntU      out  counter increment
//   cntD      out  counter decrement
//   busy      out  controller not idle
//   step      out  strobe coincident with each decrement
//   done      out  completion pulse
// ---------------------------------------------------------------------------
module counter_5bit_seq
  import cnt_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] target,
  input  logic         hold,
  input  logic         abort,
  input  logic [W-1:0] cnt_val,
  input  logic         cnt_zero,
  output logic         rst5,
  output logic         cntU,
  output logic         cntD,
  output logic         busy,
  output logic         step,
  output logic         done
);

  cnt_seq_state_t state;
  cnt_seq_state_t state_next;
  logic [W-1:0]   tgt_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Target capture; only an accepted start (in IDLE) may change it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q <= {W{1'b0}};
    end else if ((state == IDLE) && start) begin
      tgt_q <= target;
    end else begin
      tgt_q <= tgt_q;
    end
  end

  // Next-state and output decode. Abort outranks hold; hold also blocks
  // the UP->DOWN and DOWN->DONE transitions so every hold costs one cycle.
  always_comb begin
    state_next = state;
    rst5       = 1'b0;
    cntU       = 1'b0;
    cntD       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CLR;
        end else begin
          state_next = IDLE;
        end
      end
      CLR: begin
        rst5 = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          state_next = UP;
        end
      end
      UP: begin
        if (abort) begin
          rst5       = 1'b1;
          state_next = IDLE;
        end else if (hold) begin
          state_next = UP;
        end else if (cnt_val == tgt_q) begin
          state_next = DOWN;
        end else begin
          cntU       = 1'b1;
          state_next = UP;
        end
      end
      DOWN: begin
        if (abort) begin
          rst5       = 1'b1;
          state_next = IDLE;
        end else if (hold) begin
          state_next = DOWN;
        end else if (cnt_zero) begin
          state_next = DONE;
        end else begin
          cntD       = 1'b1;
          step       = 1'b1;
          state_next = DOWN;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_5bit_seq.sv
// ---------------------------------------------------------------------------
// tb_counter_5bit_seq
// Scoreboard bench for the fill/drain sequencer. The driver issues sequences
// and pushes the expected step/done events (value and cycle) derived from the
// fill/drain rules; a negedge monitor pops and compares whenever step or done
// appears. A second copy of the system (the wrapper) runs on the same stimulus.
// ---------------------------------------------------------------------------
module tb_counter_5bit_seq;
  import cnt_seq_pkg::*;

  localparam int W = CNT_W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] cnt_val;
  logic         cnt_zero;
  logic         rst5, cntU, cntD, busy, step, done;
  logic         cnt_rst;
  logic [W-1:0] sys_cnt_val;
  logic         sys_busy, sys_step, sys_done;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  cntu_seen = 0;
  int  base = 0;
  logic exp_busy = 1'b0;
  logic exp_rst5 = 1'b0;
  logic mon_en = 1'b0;

  typedef struct {
    bit           is_done;
    logic [W-1:0] val;
    int           at;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  bit  hold_arr [0:511];

  assign cnt_rst = ~rst;

  counter_5bit_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .hold(hold),
    .abort(abort), .cnt_val(cnt_val), .cnt_zero(cnt_zero), .rst5(rst5),
    .cntU(cntU), .cntD(cntD), .busy(busy), .step(step), .done(done)
  );

  counter_5bit #(.W(W)) u_cnt (
    .clk(clk), .rst(cnt_rst), .rst5(rst5), .cntU(cntU), .cntD(cntD),
    .result(cnt_val), .down_done(cnt_zero)
  );

  counter_5bit_seq_top u_sys (
    .clk(clk), .rst(rst), .start(start), .target(target), .hold(hold),
    .abort(abort), .cnt_val(sys_cnt_val), .busy(sys_busy),
    .step(sys_step), .done(sys_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: per-cycle status checks and scoreboard pops on step/done.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", int'(busy), int'(exp_busy));
      check("sys_busy", int'(sys_busy), int'(exp_busy));
      check("rst5", int'(rst5), int'(exp_rst5));
      check("exclusion", int'((cntU && cntD) || (rst5 && (cntU || cntD))), 0);
      if (cntU) cntu_seen <= cntu_seen + 1;
      if (step || done) begin
        if (sb.size() == 0) begin
          check(done ? "unexpected_done" : "unexpected_step", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind", int'(done), int'(mon_e.is_done));
          check("event_cycle", cyc, mon_e.at);
          if (mon_e.is_done) begin
            check("sys_done", int'(sys_done), 1);
          end else begin
            check("step_value", int'(cnt_val), int'(mon_e.val));
            check("sys_step", int'(sys_step), 1);
            check("sys_step_value", int'(sys_cnt_val), int'(mon_e.val));
          end
        end
      end
    end
  end

  task automatic clear_holds();
    for (int i = 0; i < 512; i++) hold_arr[i] = 1'b0;
  endtask

  task automatic random_holds();
    for (int i = 0; i < 512; i++) hold_arr[i] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      hold     = ($urandom_range(0, 1) != 0);
      abort    = ($urandom_range(0, 1) != 0);
      exp_busy = 1'b0;
      exp_rst5 = 1'b0;
    end
  endtask

  // One sequence of fill count n. cut_at > 0 ends it early in that relative
  // cycle, by abort (cut_rst = 0) or by asynchronous reset (cut_rst = 1).
  task automatic run_seq(input int n, input bit junk, input int cut_at, input bit cut_rst);
    int t, k, stop, last, c0;
    logic [W-1:0] v;
    @(posedge clk); #1;
    base     = cyc;
    start    = 1'b1;
    target   = W'(n);
    hold     = 1'b0;
    abort    = 1'b0;
    exp_busy = 1'b0;
    exp_rst5 = 1'b0;
    c0       = cntu_seen;
    stop     = (cut_at > 0) ? cut_at : 32'h3fff_ffff;
    // Fill: n increments plus the cycle that sees the target, each on a
    // non-held cycle, starting after the one clear cycle.
    t = 2; k = 0;
    while (k < n + 1) begin
      if (!hold_arr[t]) k++;
      t++;
    end
    // Drain: n steps with values n..1, then the cycle that sees zero.
    k = 0;
    while (k < n + 1) begin
      if (!hold_arr[t]) begin
        if (k < n && t < stop) begin
          v = W'(n - k);
          sb.push_back('{1'b0, v, base + t});
        end
        k++;
      end
      t++;
    end
    if (cut_at == 0) sb.push_back('{1'b1, {W{1'b0}}, base + t});
    last = (cut_at > 0) ? cut_at : t;
    for (int r = 1; r <= last; r++) begin
      @(posedge clk); #1;
      hold     = hold_arr[r];
      start    = junk ? ($urandom_range(0, 1) != 0) : 1'b0;
      target   = W'($urandom_range(0, 31));
      abort    = (r == last && cut_at == 0) ? ($urandom_range(0, 1) != 0) : 1'b0;
      exp_busy = 1'b1;
      exp_rst5 = (r == 1);
      if (r == cut_at) begin
        if (cut_rst) begin
          rst      = 1'b0;
          sb.delete();
          exp_busy = 1'b0;
          exp_rst5 = 1'b0;
          #1;
          check("async_reset_outputs", int'({rst5, cntU, cntD, busy, step, done}), 0);
          check("async_reset_sys", int'({sys_busy, sys_step, sys_done}), 0);
        end else begin
          abort    = 1'b1;
          exp_rst5 = 1'b1;
        end
      end
    end
    if (cut_at == 0) check("cntU_count", cntu_seen - c0, n);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({rst5, cntU, cntD, busy, step, done}), 0);
    check("reset_cnt_val", int'(cnt_val), 0);
    rst    = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // N = 5, no hold: done at cycle 14.
    clear_holds();
    run_seq(5, 1'b0, 0, 1'b0);
    idle(1);

    // N = 0: no increments or steps, done at cycle 4.
    run_seq(0, 1'b0, 0, 1'b0);

    // N = 31 with three holds in UP and two in DOWN, back to back with N = 0.
    hold_arr[5] = 1'b1; hold_arr[6] = 1'b1; hold_arr[20] = 1'b1;
    hold_arr[40] = 1'b1; hold_arr[50] = 1'b1;
    run_seq(31, 1'b0, 0, 1'b0);
    idle(2);

    // Start with another target while busy: ignored.
    clear_holds();
    run_seq(4, 1'b1, 0, 1'b0);
    idle(1);

    // Abort in DOWN while the count is 7 (N = 10), with hold also high.
    clear_holds();
    hold_arr[16] = 1'b1;
    run_seq(10, 1'b0, 16, 1'b0);
    idle(1);
    check("abort_clears_cnt", int'(cnt_val), 0);
    idle(2);

    // Async reset in UP, then a normal N = 3 sequence.
    clear_holds();
    run_seq(8, 1'b0, 6, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    check("post_reset_cnt_val", int'(cnt_val), 0);
    rst = 1'b1;
    idle(1);
    run_seq(3, 1'b0, 0, 1'b0);
    idle(1);

    // Randomised sequences with holds, ignored starts and back-to-back starts.
    for (int i = 0; i < 14; i++) begin
      random_holds();
      run_seq($urandom_range(0, 31), 1'b1, 0, 1'b0);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
    end
    idle(3);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_5bit_seq.md
# counter_5bit_seq

Sequencing controller for the `counter_5bit` up/down counter. On `start` it clears the counter, counts it up to a captured 5-bit target, then drains it back to zero, issuing one `step` strobe per decrement. It is used as a fill/drain loop controller: downstream logic consumes `step` with the counter value as an index. It sits beside one `counter_5bit` instance and owns that instance's `rst5`, `cntU` and `cntD` inputs exclusively.

## Interface
- `W`, 5, counter width; must equal the `counter_5bit` width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; state goes to IDLE immediately.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `target`  in  W  fill count N (0..31); captured into `tgt_q` on accepted `start`.
- `hold`  in  1  pause; freezes `cntU` and `cntD`, and the state does not advance.
- `abort`  in  1  cancel the sequence in progress.
- `cnt_val`  in  W  counter `result`.
- `cnt_zero`  in  1  counter `down_done`.
- `rst5`  out  1  synchronous counter clear.
- `cntU`  out  1  counter increment.
- `cntD`  out  1  counter decrement.
- `busy`  out  1  high in any state other than IDLE.
- `step`  out  1  one-cycle strobe, coincident with each `cntD`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLR, UP, DOWN, DONE. State is registered. All outputs are decoded combinationally from the state, `cnt_val`, `cnt_zero`, `hold` and `abort`.
- Reset values: state IDLE, `tgt_q` = 0. Every output is 0 while in reset.
- **IDLE:** when `start` = 1, capture `target` into `tgt_q` and go to CLR. Otherwise stay in IDLE.
- **CLR:** assert `rst5` for one cycle, then go to UP. `hold` is ignored in CLR.
- **UP:**
  - `cntU` = (`cnt_val` != `tgt_q`) && !`hold`.
  - When `cnt_val` == `tgt_q`, go to DOWN. `cntU` is low in that cycle.
- **DOWN:**
  - `cntD` = `step` = !`cnt_zero` && !`hold`.
  - When `cnt_zero` = 1, go to DONE.
- **DONE:** assert `done` for one cycle, then go to IDLE.
- **Abort:** `abort` = 1 in CLR, UP or DOWN has these effects in that same cycle:
  - `rst5` = 1, and `cntU`, `cntD` and `step` are forced to 0.
  - Next state is IDLE, with no `done` pulse.
  - `abort` has priority over `hold`. `abort` is ignored in IDLE and DONE.
- **Ignored `start`:** `start` outside IDLE is ignored, and `tgt_q` is not modified.
- **Mutual exclusion:** `cntU` and `cntD` are never high in the same cycle. `rst5` is never high together with either of them.
- **Range:** N = 31 never wraps, because the counter stops at 31 == `tgt_q`. N = 0 passes through UP and DOWN for one cycle each, with no `cntU`, `cntD` or `step`.
- **Async reset mid-sequence:** the controller returns to IDLE immediately. The counter is cleared by its own reset; no `rst5` is required.

## Timing
- Counting cycles from the edge that samples `start` as edge 0, with `hold` = 0:
  - CLR in cycle 1.
  - UP in cycles 2..N+2, with `cntU` in cycles 2..N+1.
  - DOWN in cycles N+3..2N+3, with `cntD`/`step` in cycles N+3..2N+2.
  - `done` in cycle 2N+4.
- Each `hold` cycle in UP or DOWN adds exactly one cycle to the total latency.
- `step` with index i (i = 1..N) occurs while `cnt_val` = N−i+1. The values seen are N, N−1, …, 1.
- A new `start` can be accepted in the cycle immediately after `done`, i.e. back to back with a one-cycle IDLE.

## Structure
- Shared package `cnt_seq_pkg`:
  - `cnt_seq_state_t`: enum of IDLE, CLR, UP, DOWN, DONE.
  - `CNT_W` = 5.
- No sub-module inside the controller.
- A thin top, `counter_5bit_seq_top`, instantiates `counter_5bit_seq` plus one `counter_5bit`. The counter's `rst` is driven from !`rst`, because the counter's reset is synchronous and active-high.
- The verification bench targets the top.

## Test plan
- **N = 5, no hold:** `start` with `target` = 5 → `cntU` in 5 cycles; `step` in 5 cycles with `cnt_val` 5,4,3,2,1; `done` at cycle 14; `busy` high in cycles 1..14.
- **N = 0:** `target` = 0 → no `cntU`, `cntD` or `step`; `done` at cycle 4.
- **N = 31 with hold:** `target` = 31, `hold` high for 3 cycles in UP and 2 cycles in DOWN → `cnt_val` peaks at 31 and never wraps; `done` at cycle 66 + 5 = 71.
- **Abort:** `abort` pulsed in DOWN while `cnt_val` = 7 → `rst5` = 1 in that cycle, no `done`, state IDLE, `cnt_val` = 0 in the next cycle.
- **Start while busy:** `start` with `target` = 9 during an N = 4 run → ignored; `done` at cycle 12 and exactly 4 `step` strobes.
- **Async reset:** `rst` low mid-UP → all outputs 0 immediately; after release, a `start` with `target` = 3 completes normally with `done` at cycle 10.
